// File: rtl/dekatron_step_sequencer.sv
// Step sequencer for a chain of one-hot decimal counter tubes: increment, decrement or parallel load,
// with digit-by-digit carry/borrow ripple. Define DEKATRON_SEQ_CHECK_EN to build one-hot readback checking.
module dekatron_step_sequencer #(
  parameter int DIGITS       = 4,
  parameter int PULSE_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Request,
  input  logic                 Dec,
  input  logic                 Load,
  input  logic [DIGITS*10-1:0] LoadData,
  input  logic [DIGITS*10-1:0] DigitsOut,
  output logic [DIGITS-1:0]    Step,
  output logic [DIGITS-1:0]    En,
  output logic                 Reverse,
  output logic                 Set,
  output logic [DIGITS*10-1:0] In,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Overflow,
  output logic                 Error
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PULSE_HI, S_PULSE_LO, S_DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic                 dec_op, dec_nxt;
  logic                 load_op, load_nxt;
  logic [DIGITS*10-1:0] data_op, data_nxt;
  logic                 ovf_nxt;
  logic                 pulse_end, eval, carry, bad_readback;
  logic [DIGITS-1:0]    sel, step_nxt, en_nxt;
  logic                 rev_nxt, set_nxt;
  logic [DIGITS*10-1:0] in_nxt;

  always_comb begin
    pulse_end = (cnt == LAST_CNT);
    eval      = (state == S_PULSE_LO) && pulse_end;
    // The stage has already stepped, so a wrap shows up as 0 (up) or 9 (down) on readback.
    carry     = dec_op ? DigitsOut[10*int'(idx) + 9] : DigitsOut[10*int'(idx)];
  end

`ifdef DEKATRON_SEQ_CHECK_EN
  function automatic logic is_one_hot(input logic [9:0] d);
    int n;
    n = 0;
    for (int b = 0; b < 10; b++) n += int'(d[b]);
    return n == 1;
  endfunction

  always_comb begin
    bad_readback = 1'b0;
    if (load_op) begin
      for (int d = 0; d < DIGITS; d++)
        if (!is_one_hot(DigitsOut[10*d +: 10])) bad_readback = 1'b1;
    end else begin
      bad_readback = !is_one_hot(DigitsOut[10*int'(idx) +: 10]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) Error <= 1'b0;
    else if (eval && bad_readback) Error <= 1'b1;
  end
`else
  assign bad_readback = 1'b0;
  assign Error        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dec_nxt   = dec_op;
    load_nxt  = load_op;
    data_nxt  = data_op;
    ovf_nxt   = Overflow;
    case (state)
      S_IDLE: begin
        if (Request) begin
          state_nxt = S_PULSE_HI;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          dec_nxt   = Dec & ~Load;
          load_nxt  = Load;
          data_nxt  = Load ? LoadData : '0;
          ovf_nxt   = 1'b0;
        end
      end
      S_PULSE_HI: begin
        cnt_nxt = pulse_end ? '0 : cnt + 1'b1;
        if (pulse_end) state_nxt = S_PULSE_LO;
      end
      S_PULSE_LO: begin
        cnt_nxt = pulse_end ? '0 : cnt + 1'b1;
        if (pulse_end) begin
          state_nxt = S_DONE;
          if (!bad_readback && !load_op && carry) begin
            if (idx == LAST_IDX) begin
              ovf_nxt = 1'b1;
            end else begin
              idx_nxt   = idx + 1'b1;
              state_nxt = S_PULSE_HI;
            end
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Outputs are computed from the next state so they leave the block straight from flops.
    sel      = load_nxt ? {DIGITS{1'b1}} : (DIGITS'(1) << idx_nxt);
    step_nxt = (state_nxt == S_PULSE_HI) ? sel : '0;
    en_nxt   = (state_nxt == S_PULSE_HI || state_nxt == S_PULSE_LO) ? sel : '0;
    rev_nxt  = (state_nxt != S_IDLE) && dec_nxt;
    set_nxt  = (state_nxt != S_IDLE) && load_nxt;
    in_nxt   = (state_nxt != S_IDLE) ? data_nxt : '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      dec_op   <= 1'b0;
      load_op  <= 1'b0;
      Step     <= '0;
      En       <= '0;
      Reverse  <= 1'b0;
      Set      <= 1'b0;
      In       <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      dec_op   <= dec_nxt;
      load_op  <= load_nxt;
      Step     <= step_nxt;
      En       <= en_nxt;
      Reverse  <= rev_nxt;
      Set      <= set_nxt;
      In       <= in_nxt;
      Busy     <= (state_nxt != S_IDLE);
      Done     <= (state_nxt == S_DONE);
      Overflow <= ovf_nxt;
    end
  end

  always_ff @(posedge Clk) data_op <= data_nxt;

endmodule
